// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and select register for an N:1 mux
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]  out_sel_q, out_sel_d;
  logic [SW-1:0]  ptr_q, ptr_d;

  logic           load;
  logic           found;
  logic [SW-1:0]  winner;

  // (a + k) mod N without leaving the select width
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // Scan requesters starting at the pointer; first hit wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(ptr_q, k)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr_q, k);
      end
    end
  end

  // Output register can take a beat when empty or being drained this cycle
  assign load = (state_q == EMPTY) || out_ready;

  // Grant only when a beat can be captured; suppressed during reset
  always_comb begin
    gnt = '0;
    if (!rst && load && found) gnt = N'(1) << winner;
  end

  // Next-state: capture on grant, drop to EMPTY on accept with no grant
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
    if (load && found) begin
      state_d    = FULL;
      out_data_d = in_data[int'(winner)*W +: W];
      out_sel_d  = winner;
      ptr_d      = wrap_add(winner, 1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int tests_run = 0;
  int fails = 0;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock; leaves time 1 unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic [N-1:0] exp);
    #1;
    tests_run++;
    if (gnt !== exp) begin
      fails++;
      $display("FAIL %s gnt=%b expected %b", name, gnt, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [W-1:0] d, input logic [SW-1:0] s);
    tests_run++;
    if (out_valid !== v || (v && (out_data !== d || out_sel !== s))) begin
      fails++;
      $display("FAIL %s valid=%b data=%h sel=%0d expected valid=%b data=%h sel=%0d",
               name, out_valid, out_data, out_sel, v, d, s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    in_data = {8'h03, 8'h02, 8'h01, 8'h00};
    chk_gnt("reset_gnt_0", 4'b0000);
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_state valid=%b data=%h sel=%0d expected 0 00 0", out_valid, out_data, out_sel);
    end
    chk_gnt("reset_gnt_1", 4'b0000);
    tick();
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_single_beat();
    req = 4'b0100;
    in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
    chk_gnt("single_gnt", 4'b0100);
    tick();
    req = 4'b0000;
    chk_out("single_out", 1'b1, 8'hA5, 2'd2);
    tick();
    chk_out("single_drain", 1'b0, 8'h00, 2'd0);
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 6; c++) begin
      chk_gnt("fair_gnt", 4'(1 << (c % 4)));
      tick();
      chk_out("fair_out", 1'b1, 8'(8'h10 + (c % 4)), 2'(c % 4));
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_gnt("bp_hold_gnt", 4'b0000);
      tick();
      chk_out("bp_hold_out", 1'b1, 8'h11, 2'd1);
    end
    out_ready = 1'b1;
    chk_gnt("bp_release_gnt", 4'b0100);
    tick();
    chk_out("bp_release_out", 1'b1, 8'h12, 2'd2);
    req = 4'b0000;
    tick();
    chk_out("bp_drain", 1'b0, 8'h00, 2'd0);
  endtask

  task automatic test_skip_wrap();
    logic [SW-1:0] exp_w [3];
    exp_w[0] = 2'd0; exp_w[1] = 2'd1; exp_w[2] = 2'd0;
    req = 4'b0011;
    in_data = {8'h23, 8'h22, 8'h21, 8'h20};
    for (int c = 0; c < 3; c++) begin
      chk_gnt("skip_gnt", 4'(1 << exp_w[c]));
      tick();
      chk_out("skip_out", 1'b1, 8'(8'h20 + exp_w[c]), exp_w[c]);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single_requester();
    req = 4'b0001;
    in_data = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int c = 0; c < 3; c++) begin
      chk_gnt("solo_gnt", 4'b0001);
      tick();
      chk_out("solo_out", 1'b1, 8'h40, 2'd0);
    end
    req = 4'b0000;
    tick();
    chk_out("solo_drain", 1'b0, 8'h00, 2'd0);
  endtask

  task automatic test_reset_mid();
    req = 4'b1000; out_ready = 1'b0;
    in_data = {8'h53, 8'h52, 8'h51, 8'h50};
    chk_gnt("rmid_first_gnt", 4'b1000);
    tick();
    chk_out("rmid_full", 1'b1, 8'h53, 2'd3);
    req = 4'b1111;
    rst = 1'b1;
    chk_gnt("rmid_rst_gnt", 4'b0000);
    tick();
    rst = 1'b0;
    chk_out("rmid_after_rst", 1'b0, 8'h00, 2'd0);
    req = 4'b1000;
    chk_gnt("rmid_regrant", 4'b1000);
    tick();
    chk_out("rmid_regrant_out", 1'b1, 8'h53, 2'd3);
    req = 4'b0110;
    chk_gnt("rmid_held_gnt", 4'b0000);
    out_ready = 1'b1;
    chk_gnt("rmid_ptr_wrap_gnt", 4'b0010);
    tick();
    chk_out("rmid_ptr_wrap_out", 1'b1, 8'h51, 2'd1);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fairness();
    test_backpressure();
    test_skip_wrap();
    test_single_requester();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
